// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decode-side control word in, per-stage
// pipeline controls and debug counters out.
interface ctrl_pipe_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       OpCodeD;
  logic             ValidD;
  logic [1:0]       ALUOpD;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             MemWriteD;
  logic             ALUSrcD;
  logic             RegDstD;
  logic             BranchD;
  logic             JumpD;
  logic             FlushE;
  logic [1:0]       ALUOpE;
  logic             ALUSrcE;
  logic             RegDstE;
  logic             RegWriteE;
  logic             MemtoRegE;
  logic             MemWriteE;
  logic             RegWriteM;
  logic             MemtoRegM;
  logic             MemWriteM;
  logic             RegWriteW;
  logic             MemtoRegW;
  logic             ValidE;
  logic             ValidM;
  logic             ValidW;
  logic             IllegalE;
  logic [CNT_W-1:0] RetiredCount;
  logic [CNT_W-1:0] IllegalCount;

  modport master (
    output OpCodeD, ValidD, ALUOpD, RegWriteD,
           MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           BranchD, JumpD, FlushE,
    input  ALUOpE, ALUSrcE, RegDstE, RegWriteE,
           MemtoRegE, MemWriteE, RegWriteM,
           MemtoRegM, MemWriteM, RegWriteW,
           MemtoRegW, ValidE, ValidM, ValidW,
           IllegalE, RetiredCount, IllegalCount
  );

  modport slave (
    input  OpCodeD, ValidD, ALUOpD, RegWriteD,
           MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           BranchD, JumpD, FlushE,
    output ALUOpE, ALUSrcE, RegDstE, RegWriteE,
           MemtoRegE, MemWriteE, RegWriteM,
           MemtoRegM, MemWriteM, RegWriteW,
           MemtoRegW, ValidE, ValidM, ValidW,
           IllegalE, RetiredCount, IllegalCount
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decode control bits through E/M/W
// with flush/bubble handling and saturating debug counters.
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input logic      CLK,
  input logic      RST,
  ctrl_pipe_if.slave bus
);

  logic       legalOp;
  logic       legalD;
  logic       illD;
  logic       takeD;
  logic       markIll;
  logic [1:0] aluOpN;
  logic       aluSrcN;
  logic       regDstN;
  logic       regWriteN;
  logic       memtoRegN;
  logic       memWriteN;
  logic       validN;
  logic       illegalN;

  logic [1:0] aluOpE;
  logic       aluSrcE;
  logic       regDstE;
  logic       regWriteE;
  logic       memtoRegE;
  logic       memWriteE;
  logic       validE;
  logic       illegalE;
  logic       regWriteM;
  logic       memtoRegM;
  logic       memWriteM;
  logic       validM;
  logic       regWriteW;
  logic       memtoRegW;
  logic       validW;
  logic [CNT_W-1:0] retCnt;
  logic [CNT_W-1:0] illCnt;

  // Branch/jump are resolved in decode and never travel down.
  logic unusedDBits;
  assign unusedDBits = bus.BranchD ^ bus.JumpD;

  // Opcode legality against the supported instruction set.
  always_comb begin
    legalOp = 1'b0;
    case (bus.OpCodeD)
      6'b100011, 6'b101011, 6'b000000,
      6'b000100, 6'b001000, 6'b000010: legalOp = 1'b1;
      default:                         legalOp = 1'b0;
    endcase
  end

  assign legalD  = bus.ValidD & legalOp;
  assign illD    = bus.ValidD & ~legalOp;
  assign takeD   = ~bus.FlushE & legalD;
  assign markIll = ~bus.FlushE & illD;

  // Next E-stage word: real instruction, flagged bubble, or bubble.
  always_comb begin
    aluOpN    = 2'b00;
    aluSrcN   = 1'b0;
    regDstN   = 1'b0;
    regWriteN = 1'b0;
    memtoRegN = 1'b0;
    memWriteN = 1'b0;
    validN    = 1'b0;
    illegalN  = 1'b0;
    unique case (1'b1)
      takeD: begin
        aluOpN    = bus.ALUOpD;
        aluSrcN   = bus.ALUSrcD;
        regDstN   = bus.RegDstD;
        regWriteN = bus.RegWriteD;
        memtoRegN = bus.MemtoRegD;
        memWriteN = bus.MemWriteD;
        validN    = 1'b1;
      end
      markIll: illegalN = 1'b1;
      default: ;
    endcase
  end

  // Stage registers; M and W advance every cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      aluOpE    <= 2'b00;
      aluSrcE   <= 1'b0;
      regDstE   <= 1'b0;
      regWriteE <= 1'b0;
      memtoRegE <= 1'b0;
      memWriteE <= 1'b0;
      validE    <= 1'b0;
      illegalE  <= 1'b0;
      regWriteM <= 1'b0;
      memtoRegM <= 1'b0;
      memWriteM <= 1'b0;
      validM    <= 1'b0;
      regWriteW <= 1'b0;
      memtoRegW <= 1'b0;
      validW    <= 1'b0;
    end else begin
      aluOpE    <= aluOpN;
      aluSrcE   <= aluSrcN;
      regDstE   <= regDstN;
      regWriteE <= regWriteN;
      memtoRegE <= memtoRegN;
      memWriteE <= memWriteN;
      validE    <= validN;
      illegalE  <= illegalN;
      regWriteM <= regWriteE;
      memtoRegM <= memtoRegE;
      memWriteM <= memWriteE;
      validM    <= validE;
      regWriteW <= regWriteM;
      memtoRegW <= memtoRegM;
      validW    <= validM;
    end
  end

  // Saturating retired/illegal counters, independent of each other.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      retCnt <= '0;
      illCnt <= '0;
    end else begin
      if (validW && retCnt != '1)
        retCnt <= retCnt + CNT_W'(1);
      if (markIll && illCnt != '1)
        illCnt <= illCnt + CNT_W'(1);
    end
  end

  assign bus.ALUOpE       = aluOpE;
  assign bus.ALUSrcE      = aluSrcE;
  assign bus.RegDstE      = regDstE;
  assign bus.RegWriteE    = regWriteE;
  assign bus.MemtoRegE    = memtoRegE;
  assign bus.MemWriteE    = memWriteE;
  assign bus.ValidE       = validE;
  assign bus.IllegalE     = illegalE;
  assign bus.RegWriteM    = regWriteM;
  assign bus.MemtoRegM    = memtoRegM;
  assign bus.MemWriteM    = memWriteM;
  assign bus.ValidM       = validM;
  assign bus.RegWriteW    = regWriteW;
  assign bus.MemtoRegW    = memtoRegW;
  assign bus.ValidW       = validW;
  assign bus.RetiredCount = retCnt;
  assign bus.IllegalCount = illCnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus random stream
// checked against a stage-list reference model.
module tb_ctrl_pipe;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int errors = 0;

  ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();
  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] aluOp;
    logic aluSrc, regDst, regWrite, memtoReg;
    logic memWrite, valid, illegal;
  } ctl_t;

  // stages[0]=E, [1]=M, [2]=W
  ctl_t stages[3];
  int   mRet, mIll;

  logic [5:0] legalOps[6] = '{6'b100011, 6'b101011,
    6'b000000, 6'b000100, 6'b001000, 6'b000010};

  function automatic bit isLegal(logic [5:0] op);
    foreach (legalOps[i]) if (legalOps[i] == op) return 1;
    return 0;
  endfunction

  function automatic ctl_t bubble();
    ctl_t b;
    b = '{aluOp: 2'b00, default: 1'b0};
    return b;
  endfunction

  function automatic logic [24:0] dutVec();
    return {bus.ALUOpE, bus.ALUSrcE, bus.RegDstE,
      bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE,
      bus.ValidE, bus.IllegalE, bus.RegWriteM,
      bus.MemtoRegM, bus.MemWriteM, bus.ValidM,
      bus.RegWriteW, bus.MemtoRegW, bus.ValidW,
      bus.RetiredCount, bus.IllegalCount};
  endfunction

  function automatic logic [24:0] modelVec();
    ctl_t e, m, w;
    e = stages[0]; m = stages[1]; w = stages[2];
    return {e.aluOp, e.aluSrc, e.regDst, e.regWrite,
      e.memtoReg, e.memWrite, e.valid, e.illegal,
      m.regWrite, m.memtoReg, m.memWrite, m.valid,
      w.regWrite, w.memtoReg, w.valid,
      CNT_W'(mRet), CNT_W'(mIll)};
  endfunction

  task automatic setD(input logic [5:0] op, input logic v,
    input logic [1:0] alu, input logic rw, input logic mtr,
    input logic mw, input logic as, input logic rd,
    input logic fl);
    bus.OpCodeD = op; bus.ValidD = v; bus.ALUOpD = alu;
    bus.RegWriteD = rw; bus.MemtoRegD = mtr;
    bus.MemWriteD = mw; bus.ALUSrcD = as; bus.RegDstD = rd;
    bus.BranchD = 1'b0; bus.JumpD = 1'b0; bus.FlushE = fl;
  endtask

  task automatic idle();
    setD(6'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; model shifts its stage list by the rules.
  task automatic tick();
    ctl_t nE;
    bit leg, ill;
    leg = bus.ValidD && isLegal(bus.OpCodeD);
    ill = bus.ValidD && !leg;
    nE = bubble();
    if (!RST) begin
      foreach (stages[i]) stages[i] = bubble();
      mRet = 0;
      mIll = 0;
    end else begin
      if (stages[2].valid && mRet < MAXC) mRet++;
      if (!bus.FlushE && ill && mIll < MAXC) mIll++;
      if (!bus.FlushE && leg) begin
        nE.aluOp = bus.ALUOpD; nE.aluSrc = bus.ALUSrcD;
        nE.regDst = bus.RegDstD; nE.regWrite = bus.RegWriteD;
        nE.memtoReg = bus.MemtoRegD;
        nE.memWrite = bus.MemWriteD; nE.valid = 1'b1;
      end else if (!bus.FlushE && ill) begin
        nE.illegal = 1'b1;
      end
      stages[2] = stages[1];
      stages[1] = stages[0];
      stages[0] = nE;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    setD(6'b100011, 1, 2'b11, 1, 1, 1, 1, 1, 0);
    tick();
    tick();
    checks++;
    if (dutVec() !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", dutVec());
    end
    checks++;
    if (bus.RetiredCount !== 0 || bus.IllegalCount !== 0) begin
      errors++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0",
        bus.RetiredCount, bus.IllegalCount);
    end
    RST = 1'b1;
    idle();
  endtask

  task automatic test_lw();
    doReset();
    setD(6'b100011, 1, 2'b00, 1, 1, 0, 1, 0, 0);
    tick();
    checks++;
    if ({bus.ALUSrcE, bus.RegWriteE, bus.ValidE} !== 3'b111) begin
      errors++;
      $display("FAIL lw_E got=%b exp=111",
        {bus.ALUSrcE, bus.RegWriteE, bus.ValidE});
    end
    idle();
    tick();
    checks++;
    if ({bus.RegWriteM, bus.MemtoRegM} !== 2'b11) begin
      errors++;
      $display("FAIL lw_M got=%b exp=11",
        {bus.RegWriteM, bus.MemtoRegM});
    end
    tick();
    checks++;
    if ({bus.RegWriteW, bus.MemtoRegW} !== 2'b11) begin
      errors++;
      $display("FAIL lw_W got=%b exp=11",
        {bus.RegWriteW, bus.MemtoRegW});
    end
    tick();
    checks++;
    if (bus.RetiredCount !== CNT_W'(1)) begin
      errors++;
      $display("FAIL lw_retired got=%0d exp=1", bus.RetiredCount);
    end
  endtask

  task automatic test_flush();
    doReset();
    setD(6'b101011, 1, 2'b00, 0, 0, 1, 1, 0, 1);
    tick();
    checks++;
    if ({bus.MemWriteE, bus.ValidE} !== 2'b00) begin
      errors++;
      $display("FAIL flush_E got=%b exp=00",
        {bus.MemWriteE, bus.ValidE});
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.MemWriteM !== 1'b0) begin
        errors++;
        $display("FAIL flush_memwriteM cyc=%0d got=%b exp=0",
          i, bus.MemWriteM);
      end
    end
    checks++;
    if (bus.RetiredCount !== 0) begin
      errors++;
      $display("FAIL flush_retired got=%0d exp=0", bus.RetiredCount);
    end
  endtask

  task automatic test_illegal();
    doReset();
    setD(6'b111111, 1, 2'b00, 1, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if ({bus.IllegalE, bus.RegWriteE, bus.ValidE} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_E got=%b exp=100",
        {bus.IllegalE, bus.RegWriteE, bus.ValidE});
    end
    checks++;
    if (bus.IllegalCount !== CNT_W'(1)) begin
      errors++;
      $display("FAIL illegal_count got=%0d exp=1", bus.IllegalCount);
    end
    idle();
    repeat (3) tick();
    checks++;
    if (bus.RetiredCount !== 0) begin
      errors++;
      $display("FAIL illegal_retired got=%0d exp=0",
        bus.RetiredCount);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < 5; i++) begin
      setD(6'b000000, 1, 2'b10, 1, 0, 0, 0, 1, 0);
      tick();
      checks++;
      if ({bus.ALUOpE, bus.RegDstE} !== 3'b101) begin
        errors++;
        $display("FAIL b2b_E cyc=%0d got=%b exp=101",
          i, {bus.ALUOpE, bus.RegDstE});
      end
    end
    idle();
    repeat (3) tick();
    checks++;
    if (bus.RetiredCount !== CNT_W'(5)) begin
      errors++;
      $display("FAIL b2b_retired got=%0d exp=5", bus.RetiredCount);
    end
  endtask

  task automatic test_saturate();
    doReset();
    setD(6'b001000, 1, 2'b00, 1, 0, 0, 1, 0, 0);
    repeat (20) tick();
    idle();
    repeat (3) tick();
    checks++;
    if (bus.RetiredCount !== CNT_W'(MAXC)) begin
      errors++;
      $display("FAIL sat_retired got=%0d exp=%0d",
        bus.RetiredCount, MAXC);
    end
    setD(6'b100011, 1, 2'b00, 1, 1, 0, 1, 0, 0);
    repeat (3) tick();
    RST = 1'b0;
    tick();
    checks++;
    if (dutVec() !== 25'd0) begin
      errors++;
      $display("FAIL midreset got=%h exp=0", dutVec());
    end
    RST = 1'b1;
    idle();
  endtask

  task automatic test_random();
    logic [5:0] op;
    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 70)
        op = legalOps[$urandom_range(5)];
      else
        op = 6'($urandom);
      setD(op, 1'($urandom_range(9) < 8), 2'($urandom),
        1'($urandom), 1'($urandom), 1'($urandom),
        1'($urandom), 1'($urandom),
        1'($urandom_range(9) == 0));
      bus.BranchD = 1'($urandom);
      bus.JumpD = 1'($urandom);
      RST = ($urandom_range(59) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (dutVec() !== modelVec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
          i, dutVec(), modelVec());
      end
    end
    RST = 1'b1;
    idle();
  endtask

  initial begin
    foreach (stages[i]) stages[i] = bubble();
    mRet = 0;
    mIll = 0;
    idle();
    test_reset();
    test_lw();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receives the decode-stage control word produced by the main controller and carries it down the pipeline.
- Registers the fields each stage consumes into the Execute, Memory and Writeback stages, with a flush/bubble path driven by the hazard unit.
- Qualifies every stage with a valid bit and turns unsupported opcodes into bubbles.
- Keeps saturating counters of retired and illegal instructions for debug and performance.

Parameters:
CNT_W, 32, width of RetiredCount and IllegalCount

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous reset, active-low
OpCodeD  in  6  decode-stage opcode, used only for legality check
ValidD  in  1  decode-stage instruction is real, not a bubble
ALUOpD  in  2  ALU operation class from the decoder
RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, JumpD  in  1 each  decoder control bits
FlushE  in  1  from hazard unit; inserts a bubble into the E stage
ALUOpE  out  2  E-stage ALU operation class
ALUSrcE, RegDstE  out  1 each  E-stage operand/destination selects
RegWriteE, MemtoRegE, MemWriteE  out  1 each  E-stage copies, used for forwarding/hazards
RegWriteM, MemtoRegM, MemWriteM  out  1 each  M-stage controls
RegWriteW, MemtoRegW  out  1 each  W-stage controls
ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
IllegalE  out  1  E-stage instruction had an unsupported opcode
RetiredCount  out  CNT_W  valid instructions that left W
IllegalCount  out  CNT_W  illegal opcodes that entered E

Behaviour:
- Reset is synchronous and active-low: RST=0 at a rising CLK edge clears every output register, including both counters, to 0. RST=0 overrides all other inputs.
- Legal opcodes: 6'b100011 lw, 6'b101011 sw, 6'b000000 R-type, 6'b000100 beq, 6'b001000 addi, 6'b000010 j.
- legalD = ValidD AND (OpCodeD in legal set). illD = ValidD AND NOT legalD.
- D->E register, updated every cycle:
  - FlushE=1: E loads a bubble. All E control bits = 0, ALUOpE=00, ValidE=0, IllegalE=0. FlushE wins over any D contents.
  - FlushE=0 and legalD=1: E loads the D-stage fields as presented; ValidE=1, IllegalE=0.
  - FlushE=0 and illD=1: E loads a bubble except IllegalE=1. ValidE=0; RegWriteE and MemWriteE are forced 0.
  - FlushE=0 and ValidD=0: E loads a bubble.
- BranchD and JumpD are consumed in D by next-PC logic and are not propagated.
- E->M register is free-running, no stall or flush: RegWriteM<=RegWriteE, MemtoRegM<=MemtoRegE, MemWriteM<=MemWriteE, ValidM<=ValidE.
- M->W register is free-running: RegWriteW<=RegWriteM, MemtoRegW<=MemtoRegM, ValidW<=ValidM.
- Latency: a legal instruction presented in D at edge n appears in E after edge n, in M after n+1, in W after n+2.
- RetiredCount increments on each edge where ValidW=1, i.e. when the instruction leaves W. It saturates at all-ones and does not wrap.
- IllegalCount increments on each edge where FlushE=0 and illD=1. It saturates at all-ones.
- When both counter conditions fire in the same cycle, each counter updates independently.
- Stall of D is handled upstream: the IF/ID register holds, and the hazard unit asserts FlushE with the stall. This block has no stall input.
- Reset mid-stream discards every in-flight control word. No counting happens on the reset edge.

Test Plan:
1. Reset with RST=0 for 2 cycles, then release -> all outputs 0; RetiredCount=0, IllegalCount=0.
2. lw in D (OpCodeD=100011, ALUSrcD=1, RegWriteD=1, MemtoRegD=1, ValidD=1) at edge 0 -> after edge 0: ALUSrcE=1, RegWriteE=1, ValidE=1; after edge 1: RegWriteM=1, MemtoRegM=1; after edge 2: RegWriteW=1, MemtoRegW=1; RetiredCount=1 after edge 3.
3. sw in D with FlushE=1 on the same edge -> after that edge MemWriteE=0, ValidE=0; MemWriteM never asserts; RetiredCount unchanged.
4. OpCodeD=6'b111111 with ValidD=1, RegWriteD=1 -> after the edge: IllegalE=1, RegWriteE=0, ValidE=0; IllegalCount=1; RetiredCount unchanged 3 cycles later.
5. Stream of 5 back-to-back R-type instructions (RegDstD=1, RegWriteD=1, ALUOpD=10) -> ALUOpE=10 and RegDstE=1 for 5 consecutive cycles; RetiredCount=5 after 8 edges.
6. Force RetiredCount to all-ones via CNT_W=4 and 20 retiring instructions -> RetiredCount holds 4'hF; then assert RST=0 with instructions in flight -> next cycle every output is 0.
